// File: rtl/cbus_arbiter_rr_if.sv
// CBus request/response types and the arbiter-facing interface bundle.
// master modport: the side that drives per-master requests and the memory response.
// slave modport:  the arbiter itself.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

interface cbus_arbiter_rr_if #(parameter int NUM_CH = 2);
  import cbus_pkg::*;
  localparam int IDX_W = $clog2(NUM_CH);

  cbus_req_t  [NUM_CH-1:0] ireqs;
  cbus_resp_t [NUM_CH-1:0] iresps;
  cbus_req_t               oreq;
  cbus_resp_t              oresp;
  logic       [IDX_W-1:0]  grant_idx;
  logic                    busy;

  modport master (output ireqs, oresp, input iresps, oreq, grant_idx, busy);
  modport slave  (input ireqs, oresp, output iresps, oreq, grant_idx, busy);
endinterface

// File: rtl/cbus_arbiter_rr.sv
// N-channel CBus arbiter. Grant is registered in IDLE and held for the whole
// transaction (all burst beats), released on oresp.ready & oresp.last.
// One IDLE bubble always separates consecutive transactions.
// Build option: define CBUS_ARB_RR_EN for round-robin; otherwise fixed
// priority (lowest valid index wins, rr pointer stays 0).
module cbus_arbiter_rr
  import cbus_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic            clk,
  input  logic            reset,
  cbus_arbiter_rr_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic               busy_q;
  logic [IDX_W-1:0]   win;
  logic               win_vld;

  // Winner search starting at rr_ptr; with rr_ptr pinned at 0 this is plain
  // lowest-index priority. Depends only on request valids, never on oresp.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_w;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = IDX_W'(idx);
      if (bus.ireqs[idx_w].valid) begin
        win     = idx_w;
        win_vld = 1'b1;
      end
    end
  end

  // Arbitration FSM: grant in IDLE, hold through BUSY until the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q <= win;
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Release cycle never grants: new requests wait for the next IDLE.
          if (bus.oresp.ready && bus.oresp.last) begin
            busy_q <= 1'b0;
            state  <= IDLE;
`ifdef CBUS_ARB_RR_EN
            rr_ptr <= (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
`else
            rr_ptr <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner's request passes straight through while BUSY (valid drops with it).
  always_comb begin
    bus.oreq = '0;
    if (state == BUSY) bus.oreq = bus.ireqs[grant_q];
  end

  // Memory response steered to the owner only; everyone else sees zeros.
  always_comb begin
    bus.iresps = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (state == BUSY && grant_q == IDX_W'(j)) bus.iresps[j] = bus.oresp;
    end
  end

  assign bus.grant_idx = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Cycle table for a 4-channel arbiter: each row drives reset/valids/oresp on
// the falling edge and states the expected busy and grant; the remaining
// expectations (oreq, iresps) follow from the row and are queued, then popped
// and compared 1ns later. A hand sequence checks the asynchronous reset.
module tb_cbus_arbiter_rr;
  import cbus_pkg::*;

  localparam int N = 4;
`ifdef CBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbus_arbiter_rr_if #(.NUM_CH(N)) bus ();

  cbus_arbiter_rr #(.NUM_CH(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic         rdy;
    logic         lst;
    logic         eb;
    logic [1:0]   eg;
  } vec_t;

  typedef struct {
    int           row;
    logic         eb;
    logic [1:0]   eg;
    logic         ov;
    logic [31:0]  addr;
    logic [N-1:0] rm;
    logic [N-1:0] lm;
    logic [63:0]  d;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic logic [31:0] addr_of(int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic cbus_req_t mk_req(int i, logic v);
    cbus_req_t r;
    r.valid    = v;
    r.is_write = i[0];
    r.size     = 3'd3;
    r.addr     = addr_of(i);
    r.strobe   = 8'hFF;
    r.data     = {32'hA5A5_0000, 32'(i)};
    r.len      = 8'd3;
    r.burst    = 2'd1;
    return r;
  endfunction

  task automatic add(logic rst, logic [N-1:0] v, logic rdy, logic lst, logic eb, logic [1:0] eg);
    vec_t t;
    t.rst = rst; t.v = v; t.rdy = rdy; t.lst = lst; t.eb = eb; t.eg = eg;
    tbl.push_back(t);
  endtask

  task automatic chk(string nm, int row, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(vec_t t, int row);
    exp_t e;
    reset = t.rst;
    for (int i = 0; i < N; i++) bus.ireqs[i] = mk_req(i, t.v[i]);
    bus.oresp.ready = t.rdy;
    bus.oresp.last  = t.lst;
    bus.oresp.data  = {32'hCAFE_0000, 32'(row)};
    e.row  = row;
    e.eb   = t.eb;
    e.eg   = t.eg;
    e.ov   = t.eb & t.v[t.eg];
    e.addr = t.eb ? addr_of(int'(t.eg)) : 32'h0;
    e.d    = {32'hCAFE_0000, 32'(row)};
    for (int j = 0; j < N; j++) begin
      e.rm[j] = t.eb && (j == int'(t.eg)) && t.rdy;
      e.lm[j] = t.eb && (j == int'(t.eg)) && t.lst;
    end
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk("busy", e.row, 64'(bus.busy), 64'(e.eb));
    chk("grant_idx", e.row, 64'(bus.grant_idx), 64'(e.eg));
    chk("oreq.valid", e.row, 64'(bus.oreq.valid), 64'(e.ov));
    chk("oreq.addr", e.row, 64'(bus.oreq.addr), 64'(e.addr));
    for (int j = 0; j < N; j++) begin
      chk($sformatf("iresps[%0d].ready", j), e.row, 64'(bus.iresps[j].ready), 64'(e.rm[j]));
      chk($sformatf("iresps[%0d].last", j), e.row, 64'(bus.iresps[j].last), 64'(e.lm[j]));
      chk($sformatf("iresps[%0d].data", j), e.row, bus.iresps[j].data,
          (e.eb && j == int'(e.eg)) ? e.d : 64'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) bus.ireqs[i] = mk_req(i, 1'b0);
    bus.oresp = '0;

    // reset held with ch0/ch1 requesting
    add(1, 4'b0011, 0, 0, 0, 0);
    add(1, 4'b0011, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0);
    // ch1 alone, 4-beat burst with one stall cycle
    add(0, 4'b0010, 0, 0, 0, 0);
    add(0, 4'b0010, 1, 0, 1, 1);
    add(0, 4'b0010, 0, 0, 1, 1);
    add(0, 4'b0010, 1, 0, 1, 1);
    add(0, 4'b0010, 1, 0, 1, 1);
    add(0, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b0000, 0, 0, 0, 1);
    // ch0+ch1 together, single beats: second grant depends on the build
    add(0, 4'b0011, 0, 0, 0, 1);
    add(0, 4'b0011, 1, 1, 1, 0);
    add(0, 4'b0011, 0, 0, 0, 0);
    add(0, 4'b0011, 1, 1, 1, RR ? 2'd1 : 2'd0);
    add(0, 4'b0000, 0, 0, 0, RR ? 2'd1 : 2'd0);
    // owner drops valid mid-transaction: stays BUSY, oreq.valid follows
    add(0, 4'b0001, 0, 0, 0, RR ? 2'd1 : 2'd0);
    add(0, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b0001, 1, 1, 1, 0);
    // all four valid from reset: 0,1,2,3,0 (round-robin) or 0 forever
    add(1, 4'b1111, 0, 0, 0, 0);
    add(0, 4'b1111, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, 4'b1111, 1, 1, 1, RR ? 2'(k % 4) : 2'd0);
      if (k < 4) add(0, 4'b1111, 0, 0, 0, RR ? 2'(k % 4) : 2'd0);
    end
    add(0, 4'b0000, 0, 0, 0, 0);
    // reset on beat 2 of a burst, then re-arbitration
    add(0, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 0, 1, 2);
    add(1, 4'b0100, 1, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 1, 2);
    // ch2 arrives in ch0's release cycle: granted only after the bubble
    add(0, 4'b0001, 0, 0, 0, 2);
    add(0, 4'b0101, 1, 1, 1, 0);
    add(0, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 1, 2);
    add(0, 4'b0000, 0, 0, 0, 2);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      drive(tbl[r], r);
      #1;
      check_out();
    end

    // asynchronous reset pulse between clock edges while BUSY
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) bus.ireqs[i] = mk_req(i, i == 1);
    bus.oresp = '0;
    @(negedge clk);
    #1;
    chk("async.busy_before", 100, 64'(bus.busy), 64'd1);
    chk("async.grant_before", 100, 64'(bus.grant_idx), 64'd1);
    chk("async.ovalid_before", 100, 64'(bus.oreq.valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async.busy", 101, 64'(bus.busy), 64'd0);
    chk("async.grant", 101, 64'(bus.grant_idx), 64'd0);
    chk("async.ovalid", 101, 64'(bus.oreq.valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) bus.ireqs[i] = mk_req(i, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
